// File: rtl/npu_pp_sum_acc.sv
// ---------------------------------------------------------------------------
// npu_pp_sum_acc
//
// Purpose:
//    Sits directly after the Booth sign-extension stage in an NPU MAC lane.
//    Each beat carries the four sign-extended radix-4 Booth partial-product
//    rows of one multiplication together with their negate bits. Stage 1
//    reduces the rows to a signed DWM-bit product. Stage 2 accumulates the
//    products of one dot-product vector and reports one DWS-bit signed result
//    per vector over a valid/ready handshake.
//
// Optional feature:
//    NPU_ACC_SAT_EN  when defined, the accumulator add saturates to the signed
//                    DWS-bit range instead of wrapping.
//
// Ports:
//    clk        clock
//    rst_n      synchronous active-low reset
//    in_valid   partial-product beat valid
//    in_ready   block can take a beat
//    in_last    beat is the last element of the current vector
//    lline0     row 0, {~s,s,s,pp[8:0]}, weight 2^0
//    lline1     row 1, {~s,pp[8:0]}, weight 2^2
//    lline2     row 2, {~s,pp[8:0]}, weight 2^4
//    lline3     row 3, {~s,pp[8:0]}, weight 2^6
//    neg        two's-complement +1 per row, neg[i] weight 2^(2i)
//    out_valid  result valid
//    out_ready  consumer accepts result
//    out_data   signed dot-product result
//    out_cnt    number of beats in the reported vector (wraps)
// ---------------------------------------------------------------------------
module npu_pp_sum_acc #(
   parameter int DWA     = 8,
   parameter int DWB     = 8,
   parameter int DWPPLEN = DWA + 2,
   parameter int DWM     = DWA + DWB,
   parameter int DWS     = 21,
   parameter int CNTW    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_last,
   input  logic [DWB+3:0]  lline0,
   input  logic [DWB+1:0]  lline1,
   input  logic [DWB+1:0]  lline2,
   input  logic [DWB+1:0]  lline3,
   input  logic [3:0]      neg,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DWS-1:0]  out_data,
   output logic [CNTW-1:0] out_cnt
);

   // The leading ~s / s bits of every row carry constant offsets left over
   // from the sign-extension trick; adding this constant cancels them all.
   localparam int             CORR_POS = 2 * (2 ** (DWPPLEN + 1)) + 2 ** (DWPPLEN + 3)
                                         + 2 ** (DWPPLEN + 5);
   localparam logic [DWM-1:0] CORR     = DWM'(-CORR_POS);

   logic [DWM-1:0]  raw;
   logic [DWM-1:0]  prod_in;
   logic            in_fire;

   logic [DWM-1:0]  p1_prod;
   logic            p1_last;
   logic            p1_valid;
   logic            p1_advance;

   logic [DWS-1:0]  acc;
   logic [DWS-1:0]  acc_next;
   logic [DWS-1:0]  prod_ext;
   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_next;

   // Stage 1 reduction: weight each row by its radix-4 position, fold in the
   // negate bits, then remove the sign-extension offset. Everything is taken
   // modulo 2^DWM so the result is directly the signed product.
   always_comb begin
      raw = DWM'(lline0) + (DWM'(lline1) << 2) + (DWM'(lline2) << 4) + (DWM'(lline3) << 6);
      for (int i = 0; i < 4; i++) begin
         raw = raw + (DWM'(neg[i]) << (2 * i));
      end
      prod_in = raw + CORR;
   end

   // A stage-1 beat only ever waits when it is the last of a vector and the
   // previous result has not been taken yet. The input side is ready whenever
   // stage 1 is empty or about to empty, which depends only on registered
   // state and out_ready, never on in_valid.
   always_comb begin
      p1_advance = p1_valid && (!p1_last || !out_valid || out_ready);
      in_ready   = !p1_valid || p1_advance;
      in_fire    = in_valid && in_ready;
      prod_ext   = {{(DWS - DWM){p1_prod[DWM-1]}}, p1_prod};
      cnt_next   = cnt + CNTW'(1);
   end

`ifdef NPU_ACC_SAT_EN
   localparam logic [DWS-1:0] ACC_MAX = {1'b0, {(DWS - 1){1'b1}}};
   localparam logic [DWS-1:0] ACC_MIN = {1'b1, {(DWS - 1){1'b0}}};

   logic [DWS:0] sum_wide;

   // Saturating accumulate: one guard bit exposes signed overflow, which is
   // then clamped toward the sign of the true sum. Since the clamped value is
   // what gets stored, later beats continue from the rail instead of wrapping.
   always_comb begin
      sum_wide = {acc[DWS-1], acc} + {prod_ext[DWS-1], prod_ext};
      if (sum_wide[DWS] != sum_wide[DWS-1]) begin
         acc_next = sum_wide[DWS] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_next = sum_wide[DWS-1:0];
      end
   end
`else
   // Plain two's-complement accumulate, wrapping modulo 2^DWS.
   assign acc_next = acc + prod_ext;
`endif

   // All state lives here. A last beat closes its vector by publishing the
   // running sum and clearing the accumulator in the same cycle, so the next
   // vector can start on the following beat without a bubble. The result
   // register is only overwritten once the consumer has taken the old value
   // (or in the same cycle it does), which keeps out_data stable under
   // backpressure.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p1_prod   <= '0;
         p1_last   <= 1'b0;
         p1_valid  <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_cnt   <= '0;
      end else begin
         if (in_fire) begin
            p1_prod  <= prod_in;
            p1_last  <= in_last;
            p1_valid <= 1'b1;
         end else if (p1_advance) begin
            p1_valid <= 1'b0;
         end

         if (p1_advance && p1_last) begin
            out_data  <= acc_next;
            out_cnt   <= cnt_next;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
         end else begin
            if (p1_advance) begin
               acc <= acc_next;
               cnt <= cnt_next;
            end
            if (out_valid && out_ready) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_npu_pp_sum_acc.sv
// ---------------------------------------------------------------------------
// tb_npu_pp_sum_acc
//
// Purpose:
//    Self-checking bench for npu_pp_sum_acc. Beats are built from integer
//    operand pairs (a, b) by Booth-encoding b and sign-extending the rows the
//    way the upstream stage does. The reference model is simply the running
//    sum of a*b over a vector, wrapped or clamped to DWS bits depending on
//    NPU_ACC_SAT_EN. Expected results go into a queue when the last beat is
//    accepted; a separate monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_npu_pp_sum_acc;

   localparam int DWS  = 21;
   localparam int CNTW = 8;

   typedef struct packed {
      logic [DWS-1:0]  data;
      logic [CNTW-1:0] cnt;
   } result_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            in_last = 1'b0;
   logic [11:0]     lline0 = '0;
   logic [9:0]      lline1 = '0;
   logic [9:0]      lline2 = '0;
   logic [9:0]      lline3 = '0;
   logic [3:0]      neg = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [DWS-1:0]  out_data;
   logic [CNTW-1:0] out_cnt;

   result_t exp_q[$];
   int      total = 0;
   int      bad = 0;
   longint  model_acc = 0;
   int      model_cnt = 0;
   bit      rand_ready = 1'b0;

   npu_pp_sum_acc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .lline0    (lline0),
      .lline1    (lline1),
      .lline2    (lline2),
      .lline3    (lline3),
      .neg       (neg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_cnt   (out_cnt)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Reference accumulate step: exact arithmetic, then wrap or clamp to DWS bits.
   function automatic longint accStep(input longint acc, input longint p);
      longint s;
      longint maxv;
      longint minv;
      s    = acc + p;
      maxv = (longint'(1) <<< (DWS - 1)) - 1;
      minv = -(longint'(1) <<< (DWS - 1));
`ifdef NPU_ACC_SAT_EN
      if (s > maxv) s = maxv;
      if (s < minv) s = minv;
`else
      s = s & ((longint'(1) <<< DWS) - 1);
      if (s > maxv) s = s - (longint'(1) <<< DWS);
`endif
      return s;
   endfunction

   // Booth radix-4 encode b, multiply each digit magnitude by a, and produce
   // the one's-complement-plus-negate-bit rows with the sign-extension prefix.
   task automatic encodeBeat(input int a, input int b, output logic [11:0] l0,
                             output logic [9:0] l1, output logic [9:0] l2,
                             output logic [9:0] l3, output logic [3:0] ng);
      logic [7:0] bb;
      logic [8:0] bx;
      logic [2:0] trip;
      logic [9:0] rows [4];
      logic [9:0] v;
      int         d;
      int         m;
      bb = 8'(b);
      bx = {bb, 1'b0};
      ng = '0;
      for (int i = 0; i < 4; i++) begin
         trip = bx[2*i +: 3];
         d    = int'(trip[0]) + int'(trip[1]) - 2 * int'(trip[2]);
         m    = (d < 0 ? -d : d) * a;
         v    = 10'(m);
         if (d < 0) begin
            v     = ~v;
            ng[i] = 1'b1;
         end
         rows[i] = v;
      end
      l0 = {~rows[0][9], rows[0][9], rows[0][9], rows[0][8:0]};
      l1 = {~rows[1][9], rows[1][8:0]};
      l2 = {~rows[2][9], rows[2][8:0]};
      l3 = {~rows[3][9], rows[3][8:0]};
   endtask

   // Present one beat a*b, wait (bounded) for acceptance, update the model and
   // push the expected result when the beat closes a vector. Called and
   // returns just after a rising edge, so consecutive calls are back-to-back.
   task automatic applyStimulus(input int a, input int b, input bit last);
      int waited;
      encodeBeat(a, b, lline0, lline1, lline2, lline3, neg);
      in_last  = last;
      in_valid = 1'b1;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checkOutput("beat_accept_timeout", longint'(in_ready), 1);
      end else begin
         @(posedge clk);
         #1;
         model_acc = accStep(model_acc, longint'(a * b));
         model_cnt++;
         if (last) begin
            exp_q.push_back({DWS'(model_acc), CNTW'(model_cnt)});
            model_acc = 0;
            model_cnt = 0;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until every expected result has been consumed.
   task automatic waitDrain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      checkOutput("drain_remaining", longint'(exp_q.size()), 0);
      idleCycles(2);
   endtask

   // Random consumer backpressure while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: on every output handshake pop the oldest expected result and
   // compare; also require the result to hold while it is being stalled.
   initial begin
      result_t         e;
      logic            prev_hold;
      logic [DWS-1:0]  prev_data;
      logic [CNTW-1:0] prev_cnt;
      prev_hold = 1'b0;
      prev_data = '0;
      prev_cnt  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold && out_valid) begin
               checkOutput("hold_data", longint'(signed'(out_data)), longint'(signed'(prev_data)));
               checkOutput("hold_cnt", longint'(out_cnt), longint'(prev_cnt));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_result: actual=%0d required=none",
                           signed'(out_data));
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("result_data", longint'(signed'(out_data)), longint'(signed'(e.data)));
                  checkOutput("result_cnt", longint'(out_cnt), longint'(e.cnt));
               end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_cnt  = out_cnt;
         end
      end
   end

   // Main sequence: reset, directed corner cases, then a randomized run.
   initial begin
      int len;
      int a;
      int b;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_out_valid", longint'(out_valid), 0);
      checkOutput("reset_out_data", longint'(out_data), 0);
      checkOutput("reset_out_cnt", longint'(out_cnt), 0);
      checkOutput("reset_in_ready", longint'(in_ready), 1);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      idleCycles(1);

      $display("[TB] directed 1*1 with latency");
      applyStimulus(1, 1, 1'b1);
      @(negedge clk);
      checkOutput("latency_t1_valid", longint'(out_valid), 0);
      @(negedge clk);
      checkOutput("latency_t2_valid", longint'(out_valid), 1);
      idleCycles(1);

      $display("[TB] directed (-1)*1 then 1*1");
      applyStimulus(-1, 1, 1'b0);
      applyStimulus(1, 1, 1'b1);

      $display("[TB] directed (-128)*(-128) x4");
      for (int i = 0; i < 4; i++) applyStimulus(-128, -128, i == 3);
      waitDrain();

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(1, 1, 1'b1);
      applyStimulus(1, 1, 1'b1);
      fork
         applyStimulus(1, 1, 1'b1);
         begin
            repeat (3) begin
               @(negedge clk);
               checkOutput("bp_in_ready_low", longint'(in_ready), 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      waitDrain();

      $display("[TB] 64-beat wrap/saturation");
      for (int i = 0; i < 64; i++) applyStimulus(-128, -128, i == 63);
      waitDrain();

      $display("[TB] reset mid-vector");
      for (int i = 0; i < 3; i++) applyStimulus(37, -91, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      model_acc = 0;
      model_cnt = 0;
      @(negedge clk);
      checkOutput("midreset_out_valid", longint'(out_valid), 0);
      checkOutput("midreset_out_data", longint'(out_data), 0);
      checkOutput("midreset_in_ready", longint'(in_ready), 1);
      idleCycles(1);
      applyStimulus(1, 1, 1'b1);
      waitDrain();

      $display("[TB] randomized vectors");
      rand_ready = 1'b1;
      for (int v = 0; v < 40; v++) begin
         len = int'($urandom_range(1, 6));
         for (int i = 0; i < len; i++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            applyStimulus(a, b, i == len - 1);
            if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 2)));
         end
      end
      @(posedge clk);
      #1;
      rand_ready = 1'b0;
      #1;
      out_ready = 1'b1;
      waitDrain();
      checkOutput("scoreboard_empty", longint'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
